// File: rtl/dac_tx_stream_feeder.sv
// Link-clock feeder for the JESD204C TX transport: buffers user words, aligns to the
// frame marker, prefills, then streams one word per cycle with zero-fill on underflow.
module dac_tx_stream_feeder #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREFILL = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     link_ready,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_sync,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_sync,
  output logic                     dout_vld,
  output logic                     underflow,
  output logic [31:0]              underflow_cnt,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [1:0]               state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL    = FW'(DEPTH);
  localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_PREFILL   = 2'd2,
    ST_STREAM    = 2'd3
  } state_e;

  state_e              state_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [DATA_W-1:0]   mem_data_q [DEPTH];
  logic                mem_sync_q [DEPTH];

  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_sync_q, rd_sync_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_sync_q;
  logic                dout_vld_q;
  logic                underflow_q, underflow_d;
  logic [31:0]         underflow_cnt_q, underflow_cnt_d;

  logic                accept;
  logic                wr_en;
  logic                rd_en;

  assign din_rdy = (state_q != ST_IDLE) && (fill_q != FULL_LVL);
  assign accept  = din_vld && din_rdy;

  // Words ahead of the first frame marker are accepted but dropped on the floor.
  always_comb begin
    wr_en           = accept && link_ready && ((state_q != ST_WAIT_SYNC) || din_sync);
    rd_en           = link_ready && (state_q == ST_STREAM) && (fill_q != '0);
    underflow_d     = (state_q == ST_STREAM) && (fill_q == '0);
    underflow_cnt_d = underflow_cnt_q;
    if (underflow_d && (underflow_cnt_q != '1)) begin
      underflow_cnt_d = underflow_cnt_q + 32'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (!link_ready) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      fill_d = fill_q + FW'(wr_en) - FW'(rd_en);
    end
  end

  always_comb begin
    rd_vld_d  = rd_en;
    rd_data_d = '0;
    rd_sync_d = 1'b0;
    if (rd_en) begin
      rd_data_d = mem_data_q[rd_ptr_q];
      rd_sync_d = mem_sync_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= din;
      mem_sync_q[wr_ptr_q] <= din_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (!link_ready) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_q <= ST_WAIT_SYNC;
        ST_WAIT_SYNC: if (accept && din_sync)     state_q <= ST_PREFILL;
        ST_PREFILL:   if (fill_q >= PREFILL_LVL)  state_q <= ST_STREAM;
        ST_STREAM:    if (fill_q == '0)           state_q <= ST_WAIT_SYNC;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // A link drop also discards the word already in flight, so dout goes quiet at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q       <= '0;
      rd_sync_q       <= 1'b0;
      rd_vld_q        <= 1'b0;
      dout_q          <= '0;
      dout_sync_q     <= 1'b0;
      dout_vld_q      <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
      if (!link_ready) begin
        rd_data_q   <= '0;
        rd_sync_q   <= 1'b0;
        rd_vld_q    <= 1'b0;
        dout_q      <= '0;
        dout_sync_q <= 1'b0;
        dout_vld_q  <= 1'b0;
      end else begin
        rd_data_q   <= rd_data_d;
        rd_sync_q   <= rd_sync_d;
        rd_vld_q    <= rd_vld_d;
        dout_q      <= rd_data_q;
        dout_sync_q <= rd_sync_q;
        dout_vld_q  <= rd_vld_q;
      end
    end
  end

  assign dout          = dout_q;
  assign dout_sync     = dout_sync_q;
  assign dout_vld      = dout_vld_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign fill          = fill_q;
  assign state         = state_q;

endmodule

// File: tb/tb_dac_tx_stream_feeder.sv
// Bench for dac_tx_stream_feeder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_dac_tx_stream_feeder;

  localparam int DATA_W  = 512;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int FW      = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              link_ready;
  logic [DATA_W-1:0] din;
  logic              din_sync;
  logic              din_vld;
  logic              din_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_sync;
  logic              dout_vld;
  logic              underflow;
  logic [31:0]       underflow_cnt;
  logic [FW-1:0]     fill;
  logic [1:0]        state;

  dac_tx_stream_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PREFILL(PREFILL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link_ready   (link_ready),
    .din          (din),
    .din_sync     (din_sync),
    .din_vld      (din_vld),
    .din_rdy      (din_rdy),
    .dout         (dout),
    .dout_sync    (dout_sync),
    .dout_vld     (dout_vld),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt),
    .fill         (fill),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              s;
  } word_t;

  // Reference model: mode 0 idle, 1 hunting for marker, 2 prefilling, 3 streaming.
  word_t             q[$];
  int                mMode;
  logic [DATA_W-1:0] stgD, outD;
  logic              stgS, stgV, outS, outV;
  logic              expUnder;
  logic [31:0]       expCnt;

  function automatic void modelReset();
    q.delete();
    mMode    = 0;
    stgD     = '0; stgS = 1'b0; stgV = 1'b0;
    outD     = '0; outS = 1'b0; outV = 1'b0;
    expUnder = 1'b0;
    expCnt   = '0;
  endfunction

  function automatic void modelStep();
    int    sz    = q.size();
    bit    rdy   = (mMode != 0) && (sz != DEPTH);
    bit    acc   = din_vld && rdy;
    bit    under = (mMode == 3) && (sz == 0);
    word_t w;
    expUnder = under;
    if (under && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
    if (!link_ready) begin
      q.delete();
      mMode = 0;
      stgD = '0; stgS = 1'b0; stgV = 1'b0;
      outD = '0; outS = 1'b0; outV = 1'b0;
      return;
    end
    outD = stgD; outS = stgS; outV = stgV;
    if (mMode == 3 && sz > 0) begin
      w = q.pop_front();
      stgD = w.d; stgS = w.s; stgV = 1'b1;
    end else begin
      stgD = '0; stgS = 1'b0; stgV = 1'b0;
    end
    if (acc && (mMode != 1 || din_sync)) begin
      w.d = din;
      w.s = din_sync;
      q.push_back(w);
    end
    case (mMode)
      0: mMode = 1;
      1: if (acc && din_sync) mMode = 2;
      2: if (sz >= PREFILL) mMode = 3;
      3: if (sz == 0) mMode = 1;
      default: mMode = 0;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("dout",          dout, outD);
    checkVal("dout_sync",     DATA_W'(dout_sync), DATA_W'(outS));
    checkVal("dout_vld",      DATA_W'(dout_vld), DATA_W'(outV));
    checkVal("underflow",     DATA_W'(underflow), DATA_W'(expUnder));
    checkVal("underflow_cnt", DATA_W'(underflow_cnt), DATA_W'(expCnt));
    checkVal("fill",          DATA_W'(fill), DATA_W'(q.size()));
    checkVal("state",         DATA_W'(state), DATA_W'(mMode));
    checkVal("din_rdy",       DATA_W'(din_rdy), DATA_W'((mMode != 0) && (q.size() != DEPTH)));
  endtask

  always @(posedge clk) begin
    if (rst) modelReset();
    else     modelStep();
    #1;
    checkOutput();
  end

  function automatic logic [DATA_W-1:0] wordOf(input int k);
    logic [31:0] x = 32'hC0DE_0000 | 32'(k);
    return {16{x}};
  endfunction

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic applyStimulus(input bit link, input bit vld, input logic [DATA_W-1:0] d, input bit s);
    link_ready = link;
    din_vld    = vld;
    din        = d;
    din_sync   = s;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Marker on word 0, eight words back to back, then drain to underflow.
  task automatic runTest1();
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkVal("t1_wait_sync", DATA_W'(state), DATA_W'(1));
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, wordOf(k), k == 0);
    checkVal("t1_prefill_state", DATA_W'(state), DATA_W'(2));
    checkVal("t1_prefill_fill", DATA_W'(fill), DATA_W'(8));
    idleCycle();
    checkVal("t1_stream_state", DATA_W'(state), DATA_W'(3));
    checkVal("t1_no_vld_yet", DATA_W'(dout_vld), DATA_W'(0));
    idleCycle();
    checkVal("t1_first_pop_fill", DATA_W'(fill), DATA_W'(7));
    checkVal("t1_still_no_vld", DATA_W'(dout_vld), DATA_W'(0));
    for (int k = 0; k < 8; k++) begin
      idleCycle();
      checkVal("t1_word", dout, wordOf(k));
      checkVal("t1_vld", DATA_W'(dout_vld), DATA_W'(1));
      checkVal("t1_sync", DATA_W'(dout_sync), DATA_W'(k == 0));
    end
    checkVal("t1_underflow", DATA_W'(underflow), DATA_W'(1));
    checkVal("t1_underflow_cnt", DATA_W'(underflow_cnt), DATA_W'(1));
    checkVal("t1_back_to_wait", DATA_W'(state), DATA_W'(1));
    idleCycle();
    checkVal("t3_pulse_once", DATA_W'(underflow), DATA_W'(0));
    checkVal("t3_zero_fill", dout, '0);
    checkVal("t3_vld_low", DATA_W'(dout_vld), DATA_W'(0));
    checkVal("t3_rdy_high", DATA_W'(din_rdy), DATA_W'(1));
  endtask

  task automatic drainToWait(input string name);
    int n = 0;
    while (mMode != 1 && n < 40) begin
      idleCycle();
      n++;
    end
    checkVal(name, DATA_W'(mMode), DATA_W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int n;
    int linkLow;
    logic [DATA_W-1:0] a5;
    rst        = 1'b1;
    link_ready = 1'b0;
    din_vld    = 1'b0;
    din_sync   = 1'b0;
    din        = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkVal("rst_state", DATA_W'(state), DATA_W'(0));
    checkVal("rst_rdy", DATA_W'(din_rdy), DATA_W'(0));
    checkVal("rst_vld", DATA_W'(dout_vld), DATA_W'(0));
    rst = 1'b0;

    $display("[TB] test 1/3: prefill, stream, underflow");
    runTest1();

    $display("[TB] test 2: words before marker discarded");
    a5 = {64{8'hA5}};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, {16{32'h1111_1111 * (k + 1)}}, 1'b0);
      checkVal("t2_discard_fill", DATA_W'(fill), DATA_W'(0));
      checkVal("t2_discard_state", DATA_W'(state), DATA_W'(1));
    end
    applyStimulus(1'b1, 1'b1, a5, 1'b1);
    checkVal("t2_marker_state", DATA_W'(state), DATA_W'(2));
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b1, wordOf(100 + k), 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 12) begin
      idleCycle();
      found = dout_vld;
      n++;
    end
    checkVal("t2_first_word_seen", DATA_W'(found), DATA_W'(1));
    checkVal("t2_first_word", dout, a5);
    checkVal("t2_first_sync", DATA_W'(dout_sync), DATA_W'(1));
    drainToWait("t2_drain");

    $display("[TB] test 5: link drop mid-stream");
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, wordOf(200 + k), k == 0);
    n = 0;
    while (!(mMode == 3 && q.size() == 5) && n < 20) begin
      idleCycle();
      n++;
    end
    checkVal("t5_fill5", DATA_W'(fill), DATA_W'(5));
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkVal("t5_idle", DATA_W'(state), DATA_W'(0));
    checkVal("t5_fill0", DATA_W'(fill), DATA_W'(0));
    checkVal("t5_vld0", DATA_W'(dout_vld), DATA_W'(0));
    checkVal("t5_no_underflow", DATA_W'(underflow), DATA_W'(0));
    checkVal("t5_cnt", DATA_W'(underflow_cnt), DATA_W'(2));

    $display("[TB] test 4: source active while link down");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b1, randWord(), k == 0);
      checkVal("t4_rdy_idle", DATA_W'(din_rdy), DATA_W'(0));
    end
    checkVal("t4_fill_idle", DATA_W'(fill), DATA_W'(0));
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, wordOf(300 + k), k == 0);
    drainToWait("t4_drain");

    $display("[TB] test 6: async reset mid-stream");
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, wordOf(400 + k), k == 0);
    checkVal("t6_pre_vld", DATA_W'(dout_vld), DATA_W'(1));
    #2;
    rst = 1'b1;
    link_ready = 1'b0;
    din_vld = 1'b0;
    #1;
    checkVal("t6_dout", dout, '0);
    checkVal("t6_vld", DATA_W'(dout_vld), DATA_W'(0));
    checkVal("t6_cnt", DATA_W'(underflow_cnt), DATA_W'(0));
    checkVal("t6_fill", DATA_W'(fill), DATA_W'(0));
    checkVal("t6_state", DATA_W'(state), DATA_W'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    runTest1();

    $display("[TB] random phase");
    linkLow = 0;
    for (int c = 0; c < 3000; c++) begin
      bit lk;
      if (linkLow > 0) begin
        lk = 1'b0;
        linkLow--;
      end else if ($urandom_range(0, 63) == 0) begin
        lk = 1'b0;
        linkLow = $urandom_range(0, 2);
      end else begin
        lk = 1'b1;
      end
      applyStimulus(lk, $urandom_range(0, 3) != 0, randWord(), $urandom_range(0, 7) == 0);
    end
    for (int k = 0; k < 5; k++) idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
